// File: rtl/sender_if.sv
// Downstream word channel between the sender and its consumer.
// Latency: none, wires only.
// Backpressure: consumer holds ready low to stall the word offered on valid/data.
//
// Ports (modports):
//   master - drives valid and data, samples ready (used by sender)
//   slave  - samples valid and data, drives ready (used by the consumer)
interface sender_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/sender.sv
// Buffered word sender: plays mem[0..len-1] downstream with GAP idle cycles before each word.
// Latency: first valid after edge N+GAP+1 for start sampled at edge N; next word GAP+1 cycles after each transfer.
// Backpressure: valid/data are held stable while ready is low; stalled cycles are counted when enabled.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   wr_en/addr/data   - buffer write port, honoured only while idle
//   start, len        - begin a transmission of len words (clamped to DEPTH), honoured only while idle
//   tx (master)       - downstream valid/ready/data channel
//   busy, done        - busy outside IDLE, one-cycle done pulse when a transmission ends
//   stall_cnt         - cycles with valid=1 and ready=0, saturating
//
// Build option: define SENDER_STALL_CNT_EN to implement the stall counter;
// otherwise stall_cnt is tied to zero and no counter logic exists.
module sender #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int GAP        = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   len,
    sender_if.master                 tx,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // Gap counter needs at least one bit even when GAP is zero.
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [GW-1:0] GAP_L   = GW'(GAP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    // idx is one bit wider than the address so it can reach DEPTH without wrapping.
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         idx_q, idx_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LW-1:0]         len_clamped;
    logic                  last_word;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
    assign last_word   = (idx_q + LW'(1)) == len_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // A zero-length request still produces its done pulse.
                    state_d = (len_clamped == '0) ? FIN : WAIT;
                end
            end
            WAIT: begin
                if (gap_q == '0) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx.ready) begin
                    state_d = last_word ? FIN : WAIT;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == FIN);
        tx.valid = (state_q == SEND);
        tx.data  = data_q;
    end

    // ------------------------------------------------------------------
    // Datapath: length, read index, gap counter, output word
    // ------------------------------------------------------------------
    always_comb begin
        len_d  = len_q;
        idx_d  = idx_q;
        gap_d  = gap_q;
        data_d = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = len_clamped;
                    idx_d = '0;
                    gap_d = GAP_L;
                end
            end
            WAIT: begin
                // The word is fetched on the edge that enters SEND, so a
                // write accepted together with start is already visible.
                if (gap_q == '0) begin
                    data_d = mem[idx_q[AW-1:0]];
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            SEND: begin
                if (tx.ready) begin
                    idx_d = idx_q + LW'(1);
                    gap_d = GAP_L;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            idx_q  <= '0;
            gap_q  <= '0;
            data_q <= '0;
        end else begin
            len_q  <= len_d;
            idx_q  <= idx_d;
            gap_q  <= gap_d;
            data_q <= data_d;
        end
    end

    // Buffer has no reset so its contents survive a reset of the engine.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == IDLE)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Stall counter
    // ------------------------------------------------------------------
`ifdef SENDER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == SEND) && !tx.ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sender.sv
// Self-checking bench for sender: one instance with GAP=10, one with GAP=0.
// Expected words come from a shadow copy of each buffer; timing from GAP arithmetic.
// Backpressure is exercised by holding ready low for a chosen word.
module tb_sender;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LW    = 5;
`ifdef SENDER_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          wr_en;
    logic          wr_all;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start_a, start_b;
    logic [LW-1:0] len;
    logic          ready;
    logic          sel_b;
    logic          we_a, we_b;
    logic          busy_a, done_a, busy_b, done_b;
    logic [15:0]   stall_a, stall_b;

    logic          cur_valid, cur_busy, cur_done;
    logic [DW-1:0] cur_data;
    logic [15:0]   cur_stall;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] m_a [DEPTH];
    logic [DW-1:0] m_b [DEPTH];

    sender_if #(.DATA_WIDTH(DW)) tx_a ();
    sender_if #(.DATA_WIDTH(DW)) tx_b ();

    assign tx_a.ready = ready;
    assign tx_b.ready = ready;
    assign we_a = wr_en & (wr_all | ~sel_b);
    assign we_b = wr_en & (wr_all | sel_b);

    sender #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP(10)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (we_a),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start_a),
        .len       (len),
        .tx        (tx_a),
        .busy      (busy_a),
        .done      (done_a),
        .stall_cnt (stall_a)
    );

    sender #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (we_b),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start_b),
        .len       (len),
        .tx        (tx_b),
        .busy      (busy_b),
        .done      (done_b),
        .stall_cnt (stall_b)
    );

    assign cur_valid = sel_b ? tx_b.valid : tx_a.valid;
    assign cur_data  = sel_b ? tx_b.data  : tx_a.data;
    assign cur_busy  = sel_b ? busy_b     : busy_a;
    assign cur_done  = sel_b ? done_b     : done_a;
    assign cur_stall = sel_b ? stall_b    : stall_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_all  = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = d;
        tick();
        wr_en = 1'b0;
        m_a[a] = d;
        m_b[a] = d;
    endtask

    // One transmission on the selected instance.
    //   stall_w/stall_n : hold ready low for stall_n cycles on word stall_w
    //   poke            : pulse start and a write to addr 0 while busy
    //   rst_after       : assert reset right after this many transfers (0 = never)
    //   wr_first        : write AA to addr 0 in the same cycle as start
    task automatic run(input int n, input bit use_b, input int stall_w, input int stall_n,
                       input bit poke, input int rst_after, input bit wr_first);
        int gap;
        int cnt;
        int exp_stall;
        logic [DW-1:0] q[$];
        sel_b = use_b;
        gap   = use_b ? 0 : 10;
        cnt   = (n > DEPTH) ? DEPTH : n;
        if (wr_first) begin
            if (use_b) m_b[0] = 8'hAA; else m_a[0] = 8'hAA;
            wr_en   = 1'b1;
            wr_all  = 1'b0;
            wr_addr = '0;
            wr_data = 8'hAA;
        end
        for (int i = 0; i < cnt; i++) q.push_back(use_b ? m_b[i] : m_a[i]);
        exp_stall = (STALL_EN && stall_w >= 0 && stall_w < cnt) ? stall_n : 0;
        len   = n[LW-1:0];
        ready = 1'b1;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        wr_en   = 1'b0;
        wr_all  = 1'b1;
        chk("busy_after_start", 32'(cur_busy), 32'd1);
        if (cnt == 0) begin
            chk("len0_done", 32'(cur_done), 32'd1);
            chk("len0_valid", 32'(cur_valid), 32'd0);
            tick();
            chk("len0_done_drop", 32'(cur_done), 32'd0);
            chk("len0_idle", 32'(cur_busy), 32'd0);
            return;
        end
        for (int w = 0; w < cnt; w++) begin
            for (int c = 0; c <= gap; c++) begin
                chk("gap_valid_low", 32'(cur_valid), 32'd0);
                chk("gap_no_done", 32'(cur_done), 32'd0);
                if (poke && w == 0 && c == 0) begin
                    if (use_b) start_b = 1'b1; else start_a = 1'b1;
                    len     = 5'd5;
                    wr_en   = 1'b1;
                    wr_all  = 1'b0;
                    wr_addr = '0;
                    wr_data = 8'hAA;
                end
                tick();
                start_a = 1'b0;
                start_b = 1'b0;
                wr_en   = 1'b0;
                wr_all  = 1'b1;
            end
            chk("word_valid", 32'(cur_valid), 32'd1);
            chk("word_data", 32'(cur_data), 32'(q[w]));
            if (w == stall_w) begin
                ready = 1'b0;
                repeat (stall_n) begin
                    tick();
                    chk("stall_valid_held", 32'(cur_valid), 32'd1);
                    chk("stall_data_held", 32'(cur_data), 32'(q[w]));
                end
                ready = 1'b1;
            end
            tick();
            if (w + 1 == rst_after) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("rst_valid", 32'(cur_valid), 32'd0);
                chk("rst_busy", 32'(cur_busy), 32'd0);
                chk("rst_data", 32'(cur_data), 32'd0);
                chk("rst_stall", 32'(cur_stall), 32'd0);
                return;
            end
        end
        chk("fin_done", 32'(cur_done), 32'd1);
        chk("fin_valid", 32'(cur_valid), 32'd0);
        chk("fin_busy", 32'(cur_busy), 32'd1);
        chk("stall_cnt", 32'(cur_stall), 32'(exp_stall));
        tick();
        chk("done_pulse_end", 32'(cur_done), 32'd0);
        chk("idle_after_fin", 32'(cur_busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, sw, sn;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_all  = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        start_a = 1'b0;
        start_b = 1'b0;
        len     = '0;
        ready   = 1'b1;
        sel_b   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state of both instances.
        chk("reset_valid_a", 32'(tx_a.valid), 32'd0);
        chk("reset_data_a", 32'(tx_a.data), 32'd0);
        chk("reset_busy_a", 32'(busy_a), 32'd0);
        chk("reset_done_a", 32'(done_a), 32'd0);
        chk("reset_stall_a", 32'(stall_a), 32'd0);
        chk("reset_valid_b", 32'(tx_b.valid), 32'd0);
        chk("reset_busy_b", 32'(busy_b), 32'd0);
        chk("reset_stall_b", 32'(stall_b), 32'd0);

        for (int i = 0; i < DEPTH; i++) write_word(i, 8'(i + 1));

        run(16, 1'b0, -1, 0, 1'b0, 0, 1'b0);   // full buffer, 11-cycle spacing
        run(3,  1'b0,  1, 5, 1'b0, 0, 1'b0);   // 5-cycle stall on word 02
        run(4,  1'b1, -1, 0, 1'b0, 0, 1'b0);   // GAP=0 alternating valid
        run(0,  1'b0, -1, 0, 1'b0, 0, 1'b0);   // empty transmission
        run(20, 1'b0, -1, 0, 1'b0, 0, 1'b0);   // clamped to DEPTH
        run(16, 1'b0, -1, 0, 1'b0, 5, 1'b0);   // reset after word 5
        run(16, 1'b0, -1, 0, 1'b0, 0, 1'b0);   // restarts from mem[0], buffer intact
        run(2,  1'b0, -1, 0, 1'b1, 0, 1'b0);   // start and write ignored while busy
        run(3,  1'b0, -1, 0, 1'b0, 0, 1'b1);   // write with start, first word AA

        for (int i = 0; i < DEPTH; i++) write_word(i, 8'($urandom));
        repeat (6) begin
            n  = $urandom_range(0, 20);
            sw = $urandom_range(0, 15);
            sn = $urandom_range(1, 6);
            run(n, 1'b1, sw, sn, 1'b0, 0, 1'b0);
        end
        repeat (2) begin
            n  = $urandom_range(1, 8);
            sw = $urandom_range(0, 7);
            sn = $urandom_range(1, 6);
            run(n, 1'b0, sw, sn, 1'b0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
